// File: rtl/adder_4bit_pkg.sv
// Shared constants and result types for the registered ripple-carry adder.
package adder_4bit_pkg;

    localparam int unsigned ADDER_WIDTH_DEFAULT = 4;

    typedef struct packed {
        logic                           carryOut;
        logic [ADDER_WIDTH_DEFAULT-1:0] sum;
        logic                           overflow;
        logic                           zero;
    } adder_result_t;

endpackage

// File: rtl/adder_4bit_full_adder_1bit.sv
// One-bit full adder cell used as the leaf of the ripple chain.
module full_adder_1bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    always_comb begin
        p    = x ^ y;
        s    = p ^ cin;
        cout = (x & y) | (cin & p);
    end

endmodule

// File: rtl/adder_4bit.sv
// Registered WIDTH-bit ripple-carry adder with carry, signed-overflow and zero flags.
module adder_4bit
    import adder_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero
);

    // Width-generic counterpart of the package result type.
    typedef struct packed {
        logic             carryOut;
        logic [WIDTH-1:0] sum;
        logic             overflow;
        logic             zero;
    } res_t;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_raw;
    res_t             res_d;
    res_t             res_q;
    logic             valid_q;

    assign carry[0] = carryIn;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_1bit u_fa (
            .x    (a[i]),
            .y    (b[i]),
            .cin  (carry[i]),
            .s    (sum_raw[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        res_d          = res_q;
        res_d.sum      = sum_raw;
        res_d.carryOut = carry[WIDTH];
        res_d.overflow = carry[WIDTH] ^ carry[WIDTH-1];
        res_d.zero     = (sum_raw == '0);
    end

    // Result fields only load on valid input, so unknown operands never reach them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = res_q.sum;
    assign carryOut  = res_q.carryOut;
    assign overflow  = res_q.overflow;
    assign zero      = res_q.zero;

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: exhaustive sweep plus directed corner vectors.
module tb_adder_4bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       carryIn;
    logic       out_valid;
    logic [3:0] sum;
    logic       carryOut;
    logic       overflow;
    logic       zero;

    int unsigned n_checks;
    int unsigned n_errors;

    adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .carryIn   (carryIn),
        .out_valid (out_valid),
        .sum       (sum),
        .carryOut  (carryOut),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {out_valid, carryOut, sum[3:0], overflow, zero}
    function automatic logic [7:0] observe();
        return {out_valid, carryOut, sum, overflow, zero};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b (v,co,sum,ov,z)", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        carryIn  = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] tot;
        logic [3:0] s;
        logic       ov;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        carryIn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", observe(), 8'b0_0_0000_0_0);
        rst = 1'b0;

        // Exhaustive sweep, back-to-back valid inputs
        for (int i = 0; i < 512; i++) begin
            logic [3:0] av;
            logic [3:0] bv;
            logic       cv;
            av  = 4'(i >> 5);
            bv  = 4'(i >> 1);
            cv  = i[0];
            tot = 5'(av) + 5'(bv) + 5'(cv);
            s   = tot[3:0];
            ov  = (av[3] == bv[3]) && (s[3] != av[3]);
            drive(1'b1, av, bv, cv);
            check($sformatf("sweep a=%0d b=%0d c=%0d", av, bv, cv), observe(),
                  {1'b1, tot[4], s, ov, (s == 4'd0)});
        end

        drive(1'b1, 4'd15, 4'd1, 1'b0);
        check("wrap 15+1", observe(), 8'b1_1_0000_0_1);

        drive(1'b1, 4'd7, 4'd1, 1'b0);
        check("ovf 7+1", observe(), 8'b1_0_1000_1_0);

        drive(1'b1, 4'd8, 4'd8, 1'b0);
        check("ovf 8+8", observe(), 8'b1_1_0000_1_1);

        drive(1'b1, 4'd15, 4'd15, 1'b1);
        check("max 15+15+1", observe(), 8'b1_1_1111_0_0);

        drive(1'b1, 4'd0, 4'd0, 1'b0);
        check("zero 0+0", observe(), 8'b1_0_0000_0_1);

        drive(1'b1, 4'd3, 4'd4, 1'b1);
        check("pre-hold 3+4+1", observe(), 8'b1_0_1000_1_0);

        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
            check($sformatf("hold %0d", k), observe(), 8'b0_0_1000_1_0);
        end

        drive(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
        check("hold x-inputs", observe(), 8'b0_0_1000_1_0);

        rst = 1'b1;
        drive(1'b1, 4'd9, 4'd9, 1'b0);
        check("reset priority", observe(), 8'b0_0_0000_0_0);
        rst = 1'b0;

        drive(1'b1, 4'd2, 4'd3, 1'b0);
        check("post-reset 2+3", observe(), 8'b1_0_0101_0_0);

        drive(1'b0, 4'd0, 4'd0, 1'b0);
        check("idle after 2+3", observe(), 8'b0_0_0101_0_0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_4bit.md
Name: adder_4bit

Overview:
- Registered 4-bit binary adder with carry-in and carry-out.
- Built from a ripple chain of one-bit full adders, with a single output register stage.
- Serves as the arithmetic leaf for small datapaths.
- Also provides signed-overflow and zero status flags alongside the sum.

Parameters:
- WIDTH, 4, operand and sum width in bits. Only 4 is required to be supported; the structure must not hard-code it.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies a, b, carryIn for capture this cycle.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- carryIn  input  1  carry into bit 0.
- out_valid  output  1  sum, carryOut and flags hold a new result.
- sum  output  WIDTH  registered (a + b + carryIn) mod 2^WIDTH.
- carryOut  output  1  registered carry out of the MSB.
- overflow  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered flag, 1 when sum == 0.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high and is sampled on the rising edge of clk.
- While rst is high at an edge, all outputs are cleared on that edge: out_valid=0, sum=0, carryOut=0, overflow=0, zero=0.
- rst has priority over in_valid at the same edge.
- The combinational core is a ripple chain of WIDTH full adders:
  - bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)).
  - c_0 = carryIn.
- Exact arithmetic: {carryOut, sum} = a + b + carryIn, a (WIDTH+1)-bit result with range 0..31 for WIDTH=4.
- Latency is 1 cycle. When in_valid=1 at edge N, the result is visible after edge N, and out_valid=1 in that cycle.
- When in_valid=0 at an edge (and rst=0):
  - out_valid goes 0.
  - sum, carryOut, overflow and zero hold their previous values.
- No backpressure. A new operand set may be accepted every cycle, and back-to-back in_valid produces back-to-back results.
- Boundary: a=15, b=15, carryIn=1 gives sum=15, carryOut=1. a=0, b=0, carryIn=0 gives sum=0, carryOut=0, zero=1.
- Wrap-around: any total ≥16 sets carryOut=1, and sum holds the low 4 bits.
- overflow treats a, b and sum as signed (-8..7). It is informational only and does not affect sum or carryOut.
- X or unknown inputs while in_valid=0 must not propagate to outputs.

Decomposition:
- Shared package: the WIDTH default constant (4), and a typedef for the result struct {carryOut, sum, overflow, zero}.
- Sub-module full_adder_1bit (inputs x, y, cin; outputs s, cout), instantiated WIDTH times in a generate loop.
- The top-level holds the generate chain, flag logic and output register.

Test Plan:
- Exhaustive sweep: all a in 0..15, b in 0..15, carryIn in 0..1 (512 vectors), one per cycle with in_valid=1. Each result must arrive exactly one cycle later with {carryOut,sum} = a+b+carryIn.
- Wrap case: a=15, b=1, carryIn=0 → next cycle sum=0, carryOut=1, zero=1, overflow=0, out_valid=1.
- Signed overflow: a=7, b=1, carryIn=0 → sum=8, carryOut=0, overflow=1. Then a=8, b=8, carryIn=0 → sum=0, carryOut=1, overflow=1, zero=1.
- Maximum: a=15, b=15, carryIn=1 → sum=15, carryOut=1, overflow=0, zero=0.
- Hold behaviour: after a=3, b=4, carryIn=1 (sum=8), drive in_valid=0 with random a/b → out_valid=0, sum stays 8, carryOut stays 0.
- Reset mid-stream: assert rst on the same edge as in_valid=1 with a=9, b=9 → all outputs 0 and out_valid=0. After deasserting rst, a=2, b=3, carryIn=0 → sum=5 one cycle later.
